// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler.
// Contents: the FSM state encoding, the default WIDTH/NREQ values and a
// round-robin pick function. The function takes a request vector and the
// index of the last winner, and returns a one-hot grant.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 2;

  // Widest request vector the pick function handles. Callers zero-extend
  // their request vector to this width.
  localparam int RR_MAX = 32;

  // The search starts at last+1 (mod nreq) and walks upward, wrapping
  // around. The first requester found wins. The result is zero when no
  // request is set.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int                nreq,
                                                input int                last);
    logic [RR_MAX-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= nreq && !found) begin
        idx = (last + k) % nreq;
        if (req[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/counter_scheduler_core.sv
// counter_core: loadable up-counter shared by the scheduler.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; clears q to 0
//   en       - increment q by one (wraps modulo 2^WIDTH)
//   load     - load load_val into q; takes priority over en
//   load_val - value loaded when load is high
//   q        - counter value
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one loadable up-counter among
// NREQ requesters. A granted job loads start_val, counts up run_len times,
// then reports the final count with a one-cycle done pulse.
// Ports:
//   clk, rst  - clock; synchronous active-high reset
//   req       - per-requester level request, sampled only in IDLE
//   start_val - packed start values, slice i belongs to requester i
//   run_len   - packed increment counts, slice i belongs to requester i
//   gnt       - one-hot grant, held from LOAD through DONE
//   done      - completion pulse to the owning requester
//   result    - final count; valid with done, otherwise holds last value
//   busy      - FSM not idle
//   count     - live counter value
//   count_oe  - counter output enable, high in RUN and DONE
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_val,
  input  logic [NREQ*WIDTH-1:0] run_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  count_oe
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q;
  logic [IDX_W-1:0]  win_q, last_q;
  logic [WIDTH-1:0]  start_q, len_q, rem_q, result_q;
  logic              ctr_load, ctr_en;

  logic [RR_MAX-1:0] pick_full;
  logic [NREQ-1:0]   pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              unused_pick;

  // Arbitration, evaluated every cycle and used only when leaving IDLE.
  always_comb begin
    pick_full = rr_pick(RR_MAX'(req), NREQ, int'(last_q));
    pick      = pick_full[NREQ-1:0];
    pick_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Bits above NREQ are always zero.
  assign unused_pick = ^pick_full;

  // Next-state and counter controls.
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      IDLE: if (|req) state_d = LOAD;
      LOAD: begin
        ctr_load = 1'b1;
        state_d  = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        ctr_en = 1'b1;
        if (rem_q == WIDTH'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, operand latches and remaining-count tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      win_q    <= '0;
      last_q   <= IDX_W'(NREQ - 1);
      start_q  <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= pick;
            win_q   <= pick_idx;
            start_q <= start_val[pick_idx*WIDTH +: WIDTH];
            len_q   <= run_len[pick_idx*WIDTH +: WIDTH];
          end
        end
        LOAD: rem_q <= len_q;
        RUN:  rem_q <= rem_q - WIDTH'(1);
        DONE: begin
          result_q <= count;
          last_q   <= win_q;
          gnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (ctr_en),
    .load     (ctr_load),
    .load_val (start_q),
    .q        (count)
  );

  // In DONE, the count already holds the final value. Presenting it
  // directly lets result be valid in the same cycle as done.
  assign done     = (state_q == DONE) ? gnt_q : '0;
  assign result   = (state_q == DONE) ? count : result_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != IDLE);
  assign count_oe = (state_q == RUN) || (state_q == DONE);

endmodule
